// File: rtl/vca_seq.sv
// Voltage-controlled amplifier: signed sample times unsigned envelope via a serial shift-add multiply.
// Optional envelope smoothing is enabled by defining VCA_SMOOTH_EN.
module vca_seq #(
    parameter int DATA_W = 16,
    parameter int ENV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              low_clk,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [ENV_W-1:0]  env_in,
    output logic [DATA_W-1:0] signal_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int ACC_W = DATA_W + ENV_W + 1;
    localparam int CNT_W = $clog2(ENV_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ENV_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic              low_clk_d;
    logic              armed;
    logic [DATA_W-1:0] smp;
    logic [ENV_W-1:0]  env_op;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    logic              rise;
    logic              start;
    logic [ACC_W-1:0]  smp_ext;
    logic [ACC_W-1:0]  partial;
    logic [ENV_W-1:0]  operand;

    // armed blocks a spurious start when low_clk is already high as reset releases
    assign rise    = low_clk & ~low_clk_d & armed;
    assign start   = rise & (state == ST_IDLE);
    assign smp_ext = {{(ACC_W - DATA_W){smp[DATA_W-1]}}, smp};
    assign partial = smp_ext << cnt;

`ifdef VCA_SMOOTH_EN
    logic [ENV_W-1:0]        env_s;
    logic signed [ENV_W:0]   env_diff;
    logic signed [ENV_W:0]   env_step;
    logic [ENV_W-1:0]        env_next;
    logic                    unused_step;

    always_comb begin
        env_diff = $signed({1'b0, env_in}) - $signed({1'b0, env_s});
        env_step = env_diff >>> 3;
        env_next = env_s + env_step[ENV_W-1:0];
    end
    assign unused_step = env_step[ENV_W];
    assign operand     = env_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_s <= '0;
        end else if (start) begin
            env_s <= env_next;
        end
    end
`else
    assign operand = env_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            low_clk_d  <= 1'b0;
            armed      <= 1'b0;
            smp        <= '0;
            env_op     <= '0;
            acc        <= '0;
            cnt        <= '0;
            signal_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            low_clk_d <= low_clk;
            out_valid <= 1'b0;
            if (!low_clk) begin
                armed <= 1'b1;
            end
            if (rise && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        smp    <= sample_in;
                        env_op <= operand;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (env_op[cnt]) begin
                        acc <= acc + partial;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    signal_out <= acc[DATA_W+ENV_W-1:ENV_W];
                    out_valid  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused_acc;
    assign unused_acc = ^{acc[ACC_W-1], acc[ENV_W-1:0]};

endmodule

// File: tb/tb_vca_seq.sv
// Scoreboard bench for vca_seq: stimulus pushes expected results, a monitor pops them on out_valid.
// Expectations follow the default build unless VCA_SMOOTH_EN is defined.
module tb_vca_seq;

    logic        clk;
    logic        rst;
    logic        low_clk;
    logic [15:0] sample_in;
    logic [15:0] env_in;
    logic [15:0] signal_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc;
    int   checks;
    int   failures;

    vca_seq #(.DATA_W(16), .ENV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .low_clk    (low_clk),
        .sample_in  (sample_in),
        .env_in     (env_in),
        .signal_out (signal_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=%h required=no_output", signal_out);
            end else begin
                mon_e = q.pop_front();
                chk("signal_out", signal_out, mon_e.val);
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // One sample at a 20-clk low_clk period; operands are scrambled mid-multiply.
    task automatic issue(input logic [15:0] s, input logic [15:0] e, input logic [15:0] res);
        int busy_cnt;
        exp_t x;
        @(negedge clk);
        sample_in = s;
        env_in    = e;
        low_clk   = 1'b1;
        @(posedge clk);
        #1;
        x.val = res;
        x.cyc = cyc + 17;
        q.push_back(x);
        sample_in = 16'h5A5A;
        env_in    = 16'hA5A5;
        busy_cnt  = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (i == 9) low_clk = 1'b0;
        end
        chk("busy_cycles", busy_cnt, 16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        low_clk   = 1'b1;
        sample_in = 16'h0;
        env_in    = 16'h0;
        #100;
        chk("reset_signal_out", signal_out, 16'h0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);

        // low_clk high through reset release must not start a multiply
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_start_after_reset_busy", busy, 0);
        low_clk = 1'b0;
        repeat (2) @(negedge clk);

`ifdef VCA_SMOOTH_EN
        // Operands 0x1000, 0x1E00, 0x2A40 applied to 0x7FFF
        issue(16'h7FFF, 16'h8000, 16'h07FF);
        issue(16'h7FFF, 16'h8000, 16'h0EFF);
        issue(16'h7FFF, 16'h8000, 16'h151F);
`else
        issue(16'h7FFF, 16'h8000, 16'h3FFF);
        issue(16'h4000, 16'h8000, 16'h2000);
        issue(16'h8000, 16'hFFFF, 16'h8000);
        issue(16'h7FFF, 16'hFFFF, 16'h7FFE);
        issue(16'hFFFF, 16'h0001, 16'hFFFF);
        issue(16'h1234, 16'h0000, 16'h0000);
        issue(16'h8000, 16'h0000, 16'h0000);
        issue(16'h0100, 16'h0100, 16'h0001);
        issue(16'hC000, 16'h4000, 16'hF000);
        issue(16'hFFFF, 16'hFFFF, 16'hFFFF);
        chk("overrun_clear_at_20clk_period", overrun, 0);

        // Second rising edge about 5 clks into the multiply
        begin
            exp_t x;
            @(negedge clk);
            sample_in = 16'h4000;
            env_in    = 16'h8000;
            low_clk   = 1'b1;
            @(posedge clk);
            #1;
            x.val = 16'h2000;
            x.cyc = cyc + 17;
            q.push_back(x);
            repeat (4) @(negedge clk);
            low_clk = 1'b0;
            @(negedge clk);
            low_clk = 1'b1;
            repeat (3) @(negedge clk);
            chk("overrun_set", overrun, 1);
            low_clk = 1'b0;
            repeat (20) @(negedge clk);
            chk("overrun_sticky", overrun, 1);
        end

        // Reset in the middle of a multiply aborts it
        @(negedge clk);
        sample_in = 16'h4000;
        env_in    = 16'h8000;
        low_clk   = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_signal_out", signal_out, 16'h0);
        chk("midreset_busy", busy, 0);
        chk("midreset_overrun", overrun, 0);
        low_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("after_abort_signal_out", signal_out, 16'h0);
        issue(16'h0100, 16'h0100, 16'h0001);
`endif

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vca_seq.md
Name: vca_seq

Overview:
- Voltage-controlled amplifier stage that consumes the 16-bit envelope produced by the ADSR block.
- On each audio sample strobe it multiplies a signed audio sample by the unsigned envelope level and emits the scaled sample.
- Uses a sequential shift-add multiplier (one envelope bit per clk), so no hardware multiplier is needed.
- Sits between the oscillator/mixer and the audio output path; it is clocked by the 50 MHz clk and paced by the 44.1 kHz low_clk from frqdivmod.

Parameters:
- DATA_W, 16, width of the signed audio sample in and out.
- ENV_W, 16, width of the unsigned envelope level; also the number of multiply iterations.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  reset; asynchronous, active-low.
- low_clk  input  1  sample-rate square wave, synchronous to clk; its rising edge starts a multiply.
- sample_in  input  DATA_W  signed audio sample; sampled on the start cycle.
- env_in  input  ENV_W  unsigned envelope level (ADSR signal_out); sampled on the start cycle.
- signal_out  output  DATA_W  signed scaled sample; holds its value between updates.
- out_valid  output  1  one-clk pulse when signal_out updates.
- busy  output  1  high while a multiply is in progress.
- overrun  output  1  sticky flag: a strobe edge arrived while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - signal_out=0, out_valid=0, busy=0, overrun=0.
  - State=IDLE, edge-detect register=0, iteration counter=0.
- Edge detect:
  - low_clk_d is low_clk registered once.
  - start = low_clk & ~low_clk_d & (state==IDLE).
  - If low_clk is already high when reset releases, no start is generated until the next low-to-high transition.
- States:
  - IDLE: on start, latch sample_in and env_in, clear the accumulator, set counter=0 and busy=1, go to MUL.
  - MUL: each clk, if env bit[counter] is set, add the sign-extended sample shifted left by counter into a DATA_W+ENV_W+1 bit accumulator. Counter increments; after iteration ENV_W-1, go to DONE.
  - DONE: signal_out = accumulator bits [DATA_W+ENV_W-1:ENV_W], out_valid=1 for this single cycle, busy=0, return to IDLE.
- Latency:
  - Start cycle is the clk edge on which operands are captured.
  - out_valid is high exactly ENV_W+1 clk cycles after the start cycle (17 with defaults).
  - Throughput is one sample per ENV_W+2 clks; 1134 clks per 44.1 kHz sample gives ample margin.
- Arithmetic:
  - Result is bit-exact floor((sample_in * env_in) / 2^ENV_W), an arithmetic shift with no rounding.
  - env_in=0 gives 0.
  - env_in=0xFFFF gives slightly less than unity gain, which never overflows DATA_W.
- Boundaries:
  - A rising edge while busy (MUL or DONE) is ignored and sets overrun=1. overrun is cleared only by reset.
  - sample_in and env_in changes during MUL have no effect on the current result.
  - Reset mid-MUL aborts the multiply: no out_valid, and signal_out returns to 0.
  - Simultaneous rising edge and DONE: the edge is ignored and overrun is set, because state is not IDLE.

Optional Feature:
- Macro: VCA_SMOOTH_EN.
- Defined:
  - A register env_s (ENV_W bits, reset 0) replaces the raw envelope as the multiplier operand.
  - On each start, env_s <= env_s + ((env_in - env_s) >>> 3), computed signed at ENV_W+1 bits; this new env_s is the operand for that sample.
  - This removes zipper noise on fast envelope steps. Latency is unchanged.
- Not defined:
  - env_in is latched and used directly, as described in Behaviour.

Test Plan:
- Reset held low for 100 ns, then released -> all outputs 0; no out_valid until the first low_clk rising edge.
- sample_in=0x4000, env_in=0x8000, one low_clk rising edge -> out_valid exactly 17 clks after the start cycle, signal_out=0x2000, busy high for 16 clks.
- sample_in=0x8000 (-32768), env_in=0xFFFF -> signal_out=0x8000; sample_in=0x7FFF, env_in=0xFFFF -> signal_out=0x7FFE.
- sample_in=0xFFFF (-1), env_in=0x0001 -> signal_out=0xFFFF (floor); env_in=0 with any sample -> signal_out=0x0000.
- Drive low_clk with period 20 clks, then a second rising edge 5 clks after a start -> second edge ignored, overrun=1, first result still correct. Assert rst mid-MUL -> no out_valid, signal_out=0, overrun=0.
- With VCA_SMOOTH_EN: env_in steps from 0 to 0x8000 -> successive operands 0x1000, 0x1E00, 0x2A40, converging toward 0x8000. Without the macro, the first result uses 0x8000 directly.
